// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage hazard/forwarding bundle: the decoded operand fields going into the
// hazard unit and the redirect/stall controls coming back out of it.
interface hazard_fwd_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_en;
  logic       id_rt_en;
  logic [4:0] id_dest;
  logic       id_regwrite;
  logic       id_memread;
  logic       id_div;

  logic [1:0] fwd_rs;
  logic [1:0] fwd_rt;
  logic       stall_id;
  logic       flush_ex;
  logic       stall_all;

  // Decode side: presents the instruction in ID and consumes the controls.
  modport master (
    output id_valid, id_rs, id_rt, id_rs_en, id_rt_en,
           id_dest, id_regwrite, id_memread, id_div,
    input  fwd_rs, fwd_rt, stall_id, flush_ex, stall_all
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_en, id_rt_en,
           id_dest, id_regwrite, id_memread, id_div,
    output fwd_rs, fwd_rt, stall_id, flush_ex, stall_all
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Tracks the destinations of the instructions in EX and MEM, selects the
// operand redirect source for the instruction in ID, inserts load-use bubbles
// and freezes the whole pipeline while a multi-cycle divide occupies EX.
module hazard_fwd_ctrl #(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               resetn,
  hazard_fwd_ctrl_if.slave   bus
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EXE = 2'b10;

  // A divide stays in EX for DIV_CYCLES cycles: the accepting edge plus
  // DIV_CYCLES-1 frozen cycles counted down to zero.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {RUN, DIV_WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Destination scoreboard mirroring the ID/EX and EX/MEM pipeline registers.
  logic       ex_valid, ex_regwrite, ex_memread, ex_div;
  logic [4:0] ex_dest;
  logic       mem_valid, mem_regwrite, mem_memread;
  logic [4:0] mem_dest;

  logic ex_wa, mem_wa;
  logic rs_load_hit, rt_load_hit;
  logic load_haz;
  logic stall_all_c;
  logic flush_c;

  // Register $0 is hard-wired, so a write to it never produces a hazard.
  assign ex_wa  = ex_valid  & ex_regwrite  & (ex_dest  != 5'd0);
  assign mem_wa = mem_valid & mem_regwrite & (mem_dest != 5'd0);

  // Loads cannot forward: the ALU result in EX/MEM is the address, not the data.
  assign rs_load_hit = (ex_wa  & ex_memread  & (ex_dest  == bus.id_rs)) |
                       (mem_wa & mem_memread & (mem_dest == bus.id_rs));
  assign rt_load_hit = (ex_wa  & ex_memread  & (ex_dest  == bus.id_rt)) |
                       (mem_wa & mem_memread & (mem_dest == bus.id_rt));

  assign load_haz = bus.id_valid & ((bus.id_rs_en & rs_load_hit) |
                                    (bus.id_rt_en & rt_load_hit));

  // Redirect select for one source operand; EX wins over MEM, and a matching
  // load in EX blocks the MEM path so a stale older value is never picked.
  function automatic logic [1:0] fwd_sel(
    input logic       rd,
    input logic [4:0] src,
    input logic       e_wa,
    input logic       e_ld,
    input logic [4:0] e_dest,
    input logic       m_wa,
    input logic       m_ld,
    input logic [4:0] m_dest
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (!rd) begin
      sel = FWD_RF;
    end else if (e_wa && (e_dest == src)) begin
      sel = e_ld ? FWD_RF : FWD_EXE;
    end else if (m_wa && !m_ld && (m_dest == src)) begin
      sel = FWD_MEM;
    end
    return sel;
  endfunction

  assign bus.fwd_rs = fwd_sel(bus.id_valid & bus.id_rs_en, bus.id_rs,
                              ex_wa, ex_memread, ex_dest,
                              mem_wa, mem_memread, mem_dest);
  assign bus.fwd_rt = fwd_sel(bus.id_valid & bus.id_rt_en, bus.id_rt,
                              ex_wa, ex_memread, ex_dest,
                              mem_wa, mem_memread, mem_dest);

  // Divide FSM next state, countdown and the freeze output.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_all_c = 1'b0;
    case (state_q)
      RUN: ;
      DIV_WAIT: begin
        if (cnt_q != '0) begin
          stall_all_c = ex_valid & ex_div;
          cnt_d       = cnt_q - 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // A divide accepted into EX on this edge starts a new occupancy window.
    if (!stall_all_c && bus.id_valid && bus.id_div && !load_haz &&
        (DIV_CYCLES > 1)) begin
      state_d = DIV_WAIT;
      cnt_d   = DIV_LOAD;
    end
  end

  assign flush_c       = load_haz & ~stall_all_c;
  assign bus.stall_all = stall_all_c;
  assign bus.stall_id  = load_haz | stall_all_c;
  assign bus.flush_ex  = flush_c;

  // Divide FSM state and countdown registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard advance: hold on freeze, otherwise shift EX into MEM and load
  // either a bubble or the ID instruction into EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid     <= 1'b0;
      ex_dest      <= 5'd0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_div       <= 1'b0;
      mem_valid    <= 1'b0;
      mem_dest     <= 5'd0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
    end else if (!stall_all_c) begin
      mem_valid    <= ex_valid;
      mem_dest     <= ex_dest;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      if (flush_c) begin
        ex_valid    <= 1'b0;
        ex_dest     <= 5'd0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_div      <= 1'b0;
      end else begin
        ex_valid    <= bus.id_valid;
        ex_dest     <= bus.id_dest;
        ex_regwrite <= bus.id_regwrite;
        ex_memread  <= bus.id_memread;
        ex_div      <= bus.id_div;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: each driven ID instruction pushes
// its hand-derived expected controls; a monitor pops and compares on negedge.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic resetn;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl #(.DIV_CYCLES(8), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rse;
    logic       rte;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       dv;
  } instr_t;

  typedef struct {
    string      tag;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       sid;
    logic       fl;
    logic       sa;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t f_nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t f_alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i;
    i = '0;
    i.v = 1'b1; i.rs = s; i.rt = t; i.rse = 1'b1; i.rte = 1'b1;
    i.dest = d; i.rw = 1'b1;
    return i;
  endfunction

  function automatic instr_t f_ld(input logic [4:0] d, input logic [4:0] s);
    instr_t i;
    i = '0;
    i.v = 1'b1; i.rs = s; i.rse = 1'b1; i.dest = d; i.rw = 1'b1; i.mr = 1'b1;
    return i;
  endfunction

  function automatic instr_t f_div(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    instr_t i;
    i = f_alu(d, s, t);
    i.dv = 1'b1;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    bus.id_valid    = i.v;
    bus.id_rs       = i.rs;
    bus.id_rt       = i.rt;
    bus.id_rs_en    = i.rse;
    bus.id_rt_en    = i.rte;
    bus.id_dest     = i.dest;
    bus.id_regwrite = i.rw;
    bus.id_memread  = i.mr;
    bus.id_div      = i.dv;
  endtask

  task automatic push(input string tag, input logic [1:0] frs, input logic [1:0] frt,
                      input logic sid, input logic fl, input logic sa);
    exp_t e;
    e.tag = tag; e.frs = frs; e.frt = frt; e.sid = sid; e.fl = fl; e.sa = sa;
    exp_q.push_back(e);
  endtask

  // Present one instruction for one cycle with its expected controls.
  task automatic issue(input string tag, input instr_t i, input logic [1:0] frs,
                       input logic [1:0] frt, input logic sid, input logic fl,
                       input logic sa);
    drive(i);
    push(tag, frs, frt, sid, fl, sa);
    @(posedge clk);
    #1;
  endtask

  // Compare outputs against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".fwd_rs"},    {6'd0, bus.fwd_rs},    {6'd0, e.frs});
      check({e.tag, ".fwd_rt"},    {6'd0, bus.fwd_rt},    {6'd0, e.frt});
      check({e.tag, ".stall_id"},  {7'd0, bus.stall_id},  {7'd0, e.sid});
      check({e.tag, ".flush_ex"},  {7'd0, bus.flush_ex},  {7'd0, e.fl});
      check({e.tag, ".stall_all"}, {7'd0, bus.stall_all}, {7'd0, e.sa});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    resetn = 1'b0;
    drive(f_nop());
    @(posedge clk);
    #1;

    // Reset state, including a valid instruction presented during reset.
    issue("reset0", f_nop(), 2'b00, 2'b00, 0, 0, 0);
    issue("reset1", f_alu(3, 3, 3), 2'b00, 2'b00, 0, 0, 0);
    resetn = 1'b1;

    // EXE forwarding, then MEM forwarding when the reader repeats.
    issue("add3",     f_alu(3, 1, 2), 2'b00, 2'b00, 0, 0, 0);
    issue("sub_exe",  f_alu(6, 3, 7), 2'b10, 2'b00, 0, 0, 0);
    issue("sub_mem",  f_alu(6, 3, 7), 2'b01, 2'b00, 0, 0, 0);

    // EXE-over-MEM priority and register $0.
    issue("w5a",      f_alu(5, 1, 1), 2'b00, 2'b00, 0, 0, 0);
    issue("w5b",      f_alu(5, 2, 2), 2'b00, 2'b00, 0, 0, 0);
    issue("rd5_prio", f_alu(8, 9, 5), 2'b00, 2'b10, 0, 0, 0);
    issue("w0",       f_alu(0, 1, 1), 2'b00, 2'b00, 0, 0, 0);
    issue("rd0_ex",   f_alu(9, 0, 0), 2'b00, 2'b00, 0, 0, 0);
    issue("rd0_mem",  f_alu(10, 0, 0), 2'b00, 2'b00, 0, 0, 0);

    // Load-use: two bubbles (load in EX, then MEM), then free.
    issue("lw4",      f_ld(4, 1), 2'b00, 2'b00, 0, 0, 0);
    issue("use4_ex",  f_alu(11, 4, 2), 2'b00, 2'b00, 1, 1, 0);
    issue("use4_mem", f_alu(11, 4, 2), 2'b00, 2'b00, 1, 1, 0);
    issue("use4_go",  f_alu(11, 4, 2), 2'b00, 2'b00, 0, 0, 0);

    // Operand enables: a disabled rs match does not stall; enabled rt does.
    issue("lw4b",     f_ld(4, 1), 2'b00, 2'b00, 0, 0, 0);
    i = f_alu(12, 4, 2);
    i.rse = 1'b0;
    issue("rs_off",   i, 2'b00, 2'b00, 0, 0, 0);
    issue("rt_memld", f_alu(13, 1, 4), 2'b00, 2'b00, 1, 1, 0);
    issue("rt_go",    f_alu(13, 1, 4), 2'b00, 2'b00, 0, 0, 0);

    // Divide: seven frozen cycles with forwarding still visible, no flush.
    issue("div14",    f_div(14, 1, 2), 2'b00, 2'b00, 0, 0, 0);
    for (int k = 0; k < 7; k++)
      issue("div_busy", f_alu(15, 14, 13), 2'b10, 2'b01, 1, 0, 1);
    issue("div_rel",  f_alu(15, 14, 13), 2'b10, 2'b01, 0, 0, 0);
    issue("post_div", f_alu(16, 15, 14), 2'b10, 2'b01, 0, 0, 0);

    // Reset in the middle of a divide (countdown at 3).
    issue("div17",    f_div(17, 1, 2), 2'b00, 2'b00, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      issue("div17_busy", f_alu(18, 17, 16), 2'b10, 2'b01, 1, 0, 1);
    drive(f_alu(18, 17, 16));
    push("div17_cnt3", 2'b10, 2'b01, 1, 0, 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst.fwd_rs",    {6'd0, bus.fwd_rs},    8'd0);
    check("async_rst.fwd_rt",    {6'd0, bus.fwd_rt},    8'd0);
    check("async_rst.stall_id",  {7'd0, bus.stall_id},  8'd0);
    check("async_rst.flush_ex",  {7'd0, bus.flush_ex},  8'd0);
    check("async_rst.stall_all", {7'd0, bus.stall_all}, 8'd0);
    @(posedge clk);
    #1;
    issue("in_rst",   f_alu(18, 17, 16), 2'b00, 2'b00, 0, 0, 0);
    resetn = 1'b1;

    // Fresh stream after reset: no residual forwarding or freeze.
    issue("fresh18",  f_alu(18, 17, 16), 2'b00, 2'b00, 0, 0, 0);
    issue("fresh19",  f_alu(19, 18, 17), 2'b10, 2'b00, 0, 0, 0);
    issue("nop",      f_nop(), 2'b00, 2'b00, 0, 0, 0);

    // Load in EX shadowing an older ALU write of the same register in MEM.
    issue("w20",      f_alu(20, 1, 1), 2'b00, 2'b00, 0, 0, 0);
    issue("lw20",     f_ld(20, 1), 2'b00, 2'b00, 0, 0, 0);
    issue("use20_ex", f_alu(21, 20, 3), 2'b00, 2'b00, 1, 1, 0);
    issue("use20_mem",f_alu(21, 20, 3), 2'b00, 2'b00, 1, 1, 0);
    issue("use20_go", f_alu(21, 20, 3), 2'b00, 2'b00, 0, 0, 0);

    drive(f_nop());
    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
